data_memory_lsu: RTL and testbench
==================================

Name: data_memory_lsu

Overview:
Parametrised RV32 data memory with a load/store front end. It replaces the flat word-addressed DataMemory and sits in the MEM stage.
- Takes byte addresses, sizes and sign control; performs byte/half/word accesses with byte-lane enables.
- Flags misaligned accesses.
- Clears its own storage after reset with an init sequencer.
- Uses a valid/ready request handshake and returns a registered response after a fixed latency.

Parameters:
Width, 32, data bus width in bits; byte lanes = Width/8; 32 supported, 64 must elaborate.
Depth, 512, number of Width-bit words; power of two.
AddrWidth, 32, byte-address width.
ReadLatency, 1, accept-to-response cycles; legal values 1 or 2.

Ports:
clk  input  1  clock; all state updates on posedge.
rst_n  input  1  synchronous active-low reset.
ReqValid  input  1  request present.
ReqReady  output  1  block can accept a request this cycle.
ReqWrite  input  1  1 = store, 0 = load.
ReqSize  input  2  00 byte, 01 half, 10 word, 11 dword (legal only when Width=64).
ReqUnsigned  input  1  load zero-extends when 1, sign-extends when 0.
Addr  input  AddrWidth  byte address.
WriteData  input  Width  store data, right-aligned (LSBs).
RspValid  output  1  one-cycle response pulse, for both loads and stores.
ReadData  output  Width  extended load result; 0 for stores and faults.
Fault  output  1  qualifies RspValid; access was not performed.

Behaviour:
- Reset (rst_n=0 at posedge):
  - ReqReady=0, RspValid=0, Fault=0, ReadData=0.
  - The response pipeline is flushed; in-flight responses are dropped and never appear.
  - FSM goes to INIT with the clear counter at 0.
- FSM:
  - INIT: writes 0 to word[cnt] each cycle and increments cnt. After cnt=Depth-1 it moves to RUN, so it takes exactly Depth cycles after reset release. ReqReady=0 throughout INIT.
  - RUN: ReqReady=1 every cycle, with no internal stalls. The FSM leaves RUN only on reset.
- Accept = ReqValid & ReqReady. At most one request per cycle, pipelined, with full throughput.
- Word index = Addr[log2(Depth)+lg(Width/8)-1 : lg(Width/8)]. Byte offset = low lg(Width/8) bits. Upper address bits are ignored unless the optional feature is enabled.
- Misaligned conditions: half with offset[0]≠0; word with offset[1:0]≠0; dword with offset≠0; size 11 when Width=32.
  - Misaligned access: no memory update.
  - Response carries Fault=1 and ReadData=0.
- Store, on the accept edge:
  - Byte enables come from size and offset.
  - WriteData is shifted into the addressed lanes.
  - Only enabled bytes change.
- Load:
  - The raw word is read at the accept edge.
  - The addressed lane is extracted, then sign- or zero-extended to Width per ReqUnsigned (word loads on Width=64 also honour ReqUnsigned).
- Response timing: RspValid is asserted exactly ReadLatency cycles after the accept edge, for every accepted request, in order. With ReadLatency=2 an extra output register stage is added.
- Read-after-write: a load accepted in any cycle after a store to the same word returns the updated bytes. No same-cycle conflict is possible.
- Back-to-back accepts produce back-to-back RspValid pulses. There is no response backpressure; the consumer must always accept.
- Reset asserted during RUN re-enters INIT and re-clears the whole memory.

Optional Feature:
- Macro: DMEM_BOUNDS_CHECK_EN.
- Defined: any set address bit above the word-index field marks the access out-of-range. It is treated like a misaligned access: no write, response with Fault=1 and ReadData=0. Misaligned and out-of-range together still produce a single Fault.
- Undefined: upper bits are ignored, addresses alias modulo Depth words, and Fault is raised only for misalignment.

Test Plan:
- Reset then idle: rst_n low for 2 cycles, release → ReqReady stays 0 for exactly 512 cycles, then 1; a word load from 0x1FC returns 0x00000000.
- Byte stores then mixed loads: SB 0x80 @0x10, SB 0x7F @0x11, then LW @0x10 → 0x00007F80; LB @0x10 → 0xFFFFFF80; LBU @0x10 → 0x00000080; each RspValid lands ReadLatency cycles after its accept.
- Half/word path: SW 0xDEADBEEF @0x20, SH 0x1234 @0x22, then LH @0x22 → 0x00001234; LHU @0x20 → 0x0000BEEF; LW @0x20 → 0x1234BEEF.
- Misalignment: SW 0xFFFFFFFF @0x31 → Fault=1 and word 0x30 unchanged (LW @0x30 → 0); LH @0x33 → Fault=1, ReadData=0.
- Pipelining and latency: 8 back-to-back accepted loads with ReadLatency=1, then rerun with 2 → 8 consecutive RspValid pulses in order, starting 1 or 2 cycles after the first accept.
- Reset mid-stream: assert rst_n=0 in the cycle after a load is accepted → no RspValid appears; after INIT, all previously written locations read 0; with DMEM_BOUNDS_CHECK_EN, LW @0x800 → Fault=1.

Source files
------------

// File: rtl/data_memory_lsu.sv
// RV32 data memory with a load/store front end; clears itself after reset, then serves pipelined requests.
// Optional define DMEM_BOUNDS_CHECK_EN faults any access with address bits set above the word index.
module data_memory_lsu #(
    parameter int Width       = 32,
    parameter int Depth       = 512,
    parameter int AddrWidth   = 32,
    parameter int ReadLatency = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ReqValid,
    output logic                 ReqReady,
    input  logic                 ReqWrite,
    input  logic [1:0]           ReqSize,
    input  logic                 ReqUnsigned,
    input  logic [AddrWidth-1:0] Addr,
    input  logic [Width-1:0]     WriteData,
    output logic                 RspValid,
    output logic [Width-1:0]     ReadData,
    output logic                 Fault
);
    localparam int Lanes = Width / 8;
    localparam int OffW  = $clog2(Lanes);
    localparam int IdxW  = $clog2(Depth);

    typedef enum logic {S_INIT, S_RUN} state_e;

    state_e          state_q;
    logic [IdxW-1:0] cnt_q;
    logic            ready_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_INIT;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            case (state_q)
                S_INIT: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == IdxW'(Depth - 1)) begin
                        state_q <= S_RUN;
                        ready_q <= 1'b1;
                    end
                end
                default: ready_q <= 1'b1;
            endcase
        end
    end

    assign ReqReady = ready_q;

    logic [OffW-1:0]  off;
    logic [IdxW-1:0]  idx;
    logic [OffW-1:0]  amask;
    logic [Lanes-1:0] size_mask;
    logic [Lanes-1:0] be;
    logic [Width-1:0] wdata_sh;
    logic             misal;
    logic             oor;
    logic             fault_d;
    logic             acc;
    logic             we;

    assign off = Addr[OffW-1:0];
    assign idx = Addr[IdxW+OffW-1:OffW];

    always_comb begin
        amask     = '0;
        misal     = 1'b0;
        size_mask = '0;
        case (ReqSize)
            2'b00:   amask = '0;
            2'b01:   amask = OffW'(1);
            2'b10:   amask = OffW'(3);
            default: begin
                amask = '1;
                misal = (Width < 64);
            end
        endcase
        misal = misal | (|(off & amask));
        for (int unsigned l = 0; l < Lanes; l++) begin
            size_mask[l] = (l < (32'd1 << ReqSize));
        end
        be       = size_mask << off;
        wdata_sh = WriteData << {off, 3'b000};
    end

`ifdef DMEM_BOUNDS_CHECK_EN
    assign oor = |(Addr >> (IdxW + OffW));
`else
    logic unused_addr_hi;
    assign unused_addr_hi = |Addr[AddrWidth-1:IdxW+OffW];
    assign oor            = 1'b0;
`endif

    // rst_n gates accept so a request in the reset cycle neither writes nor responds
    assign fault_d = misal | oor;
    assign acc     = ReqValid & ready_q & rst_n;
    assign we      = acc & ReqWrite & ~fault_d;

    logic [Width-1:0] mem [Depth];
    logic [Width-1:0] raw_q;

    always_ff @(posedge clk) begin
        if (state_q == S_INIT) begin
            mem[cnt_q] <= '0;
        end else if (we) begin
            for (int unsigned l = 0; l < Lanes; l++) begin
                if (be[l]) mem[idx][l*8 +: 8] <= wdata_sh[l*8 +: 8];
            end
        end
        raw_q <= mem[idx];
    end

    logic            s1_valid_q;
    logic            s1_load_q;
    logic            s1_fault_q;
    logic            s1_uns_q;
    logic [1:0]      s1_size_q;
    logic [OffW-1:0] s1_off_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_load_q  <= 1'b0;
            s1_fault_q <= 1'b0;
            s1_uns_q   <= 1'b0;
            s1_size_q  <= '0;
            s1_off_q   <= '0;
        end else begin
            s1_valid_q <= acc;
            if (acc) begin
                s1_load_q  <= ~ReqWrite;
                s1_fault_q <= fault_d;
                s1_uns_q   <= ReqUnsigned;
                s1_size_q  <= ReqSize;
                s1_off_q   <= off;
            end
        end
    end

    logic [Width-1:0] shifted;
    logic [Width-1:0] ext_d;
    logic [Width-1:0] rsp_data_d;
    logic             sign;

    always_comb begin
        shifted = raw_q >> {s1_off_q, 3'b000};
        sign    = 1'b0;
        case (s1_size_q)
            2'b00:   sign = shifted[7];
            2'b01:   sign = shifted[15];
            2'b10:   sign = shifted[31];
            default: sign = shifted[Width-1];
        endcase
        sign  = sign & ~s1_uns_q;
        ext_d = '0;
        for (int unsigned i = 0; i < Width; i++) begin
            ext_d[i] = (i < (32'd8 << s1_size_q)) ? shifted[i] : sign;
        end
        rsp_data_d = (s1_valid_q & s1_load_q & ~s1_fault_q) ? ext_d : '0;
    end

    generate
        if (ReadLatency == 2) begin : g_lat2
            logic             out_valid_q;
            logic             out_fault_q;
            logic [Width-1:0] out_data_q;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    out_valid_q <= 1'b0;
                    out_fault_q <= 1'b0;
                    out_data_q  <= '0;
                end else begin
                    out_valid_q <= s1_valid_q;
                    out_fault_q <= s1_valid_q & s1_fault_q;
                    out_data_q  <= rsp_data_d;
                end
            end

            assign RspValid = out_valid_q;
            assign Fault    = out_fault_q;
            assign ReadData = out_data_q;
        end else begin : g_lat1
            assign RspValid = s1_valid_q;
            assign Fault    = s1_valid_q & s1_fault_q;
            assign ReadData = rsp_data_d;
        end
    endgenerate
endmodule

// File: tb/tb_data_memory_lsu.sv
// Directed bench for data_memory_lsu: latency-1 and latency-2 instances share one stimulus stream.
module tb_data_memory_lsu;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        ReqValid;
    logic        ReqWrite;
    logic [1:0]  ReqSize;
    logic        ReqUnsigned;
    logic [31:0] Addr;
    logic [31:0] WriteData;

    logic        rdy1, rv1, f1;
    logic        rdy2, rv2, f2;
    logic [31:0] rd1, rd2;

    data_memory_lsu #(.Width(32), .Depth(512), .AddrWidth(32), .ReadLatency(1)) dut_l1 (
        .clk(clk), .rst_n(rst_n), .ReqValid(ReqValid), .ReqReady(rdy1), .ReqWrite(ReqWrite),
        .ReqSize(ReqSize), .ReqUnsigned(ReqUnsigned), .Addr(Addr), .WriteData(WriteData),
        .RspValid(rv1), .ReadData(rd1), .Fault(f1)
    );

    data_memory_lsu #(.Width(32), .Depth(512), .AddrWidth(32), .ReadLatency(2)) dut_l2 (
        .clk(clk), .rst_n(rst_n), .ReqValid(ReqValid), .ReqReady(rdy2), .ReqWrite(ReqWrite),
        .ReqSize(ReqSize), .ReqUnsigned(ReqUnsigned), .Addr(Addr), .WriteData(WriteData),
        .RspValid(rv2), .ReadData(rd2), .Fault(f2)
    );

    typedef struct packed {
        logic        v;
        logic        f;
        logic [31:0] d;
    } exp_t;

    exp_t cur, p0, p1;
    int   passed = 0;
    int   failed = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assert (obs === exp) begin
            passed++;
        end else begin
            failed++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One clock; p0/p1 hold what each instance must show 1 and 2 edges after an accept.
    task automatic step();
        logic acc;
        acc = rst_n & ReqValid & rdy1;
        @(posedge clk);
        #1;
        if (!rst_n) begin
            p0 = '0;
            p1 = '0;
        end else begin
            p1 = p0;
            p0 = acc ? cur : '0;
        end
        chk("rsp_valid_l1", {31'd0, rv1}, {31'd0, p0.v});
        if (p0.v) begin
            chk("rdata_l1", rd1, p0.d);
            chk("fault_l1", {31'd0, f1}, {31'd0, p0.f});
        end
        chk("rsp_valid_l2", {31'd0, rv2}, {31'd0, p1.v});
        if (p1.v) begin
            chk("rdata_l2", rd2, p1.d);
            chk("fault_l2", {31'd0, f2}, {31'd0, p1.f});
        end
    endtask

    task automatic req(input logic w, input logic [1:0] sz, input logic u, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] ed, input logic ef);
        chk("req_ready", {31'd0, rdy1}, 32'd1);
        ReqValid    = 1'b1;
        ReqWrite    = w;
        ReqSize     = sz;
        ReqUnsigned = u;
        Addr        = a;
        WriteData   = wd;
        cur.v       = 1'b1;
        cur.f       = ef;
        cur.d       = ed;
        step();
        ReqValid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic wait_init(input string tag);
        int n;
        n = 0;
        while (rdy1 !== 1'b1 && n < 2000) begin
            step();
            n++;
        end
        chk(tag, n, 32'd512);
        chk({tag, "_l2_ready"}, {31'd0, rdy2}, 32'd1);
    endtask

    initial begin
        rst_n       = 1'b0;
        ReqValid    = 1'b0;
        ReqWrite    = 1'b0;
        ReqSize     = 2'b00;
        ReqUnsigned = 1'b0;
        Addr        = '0;
        WriteData   = '0;
        cur         = '0;
        p0          = '0;
        p1          = '0;

        idle(2);
        chk("reset_ready_l1", {31'd0, rdy1}, 32'd0);
        chk("reset_ready_l2", {31'd0, rdy2}, 32'd0);
        chk("reset_rdata_l1", rd1, 32'd0);
        chk("reset_rdata_l2", rd2, 32'd0);
        chk("reset_fault_l1", {31'd0, f1}, 32'd0);
        chk("reset_fault_l2", {31'd0, f2}, 32'd0);
        rst_n = 1'b1;
        wait_init("init_cycles");

        // w, size, uns, addr, wdata, expected rdata, expected fault
        req(0, 2'b10, 0, 32'h1FC, 32'h0,        32'h0000_0000, 0);
        req(1, 2'b00, 0, 32'h010, 32'h80,       32'h0,         0);
        req(1, 2'b00, 0, 32'h011, 32'h7F,       32'h0,         0);
        req(0, 2'b10, 0, 32'h010, 32'h0,        32'h0000_7F80, 0);
        req(0, 2'b00, 0, 32'h010, 32'h0,        32'hFFFF_FF80, 0);
        req(0, 2'b00, 1, 32'h010, 32'h0,        32'h0000_0080, 0);
        req(0, 2'b00, 0, 32'h011, 32'h0,        32'h0000_007F, 0);
        req(1, 2'b00, 0, 32'h012, 32'hFFFF_FF55, 32'h0,        0);
        req(0, 2'b10, 0, 32'h010, 32'h0,        32'h0055_7F80, 0);
        idle(2);

        req(1, 2'b10, 0, 32'h020, 32'hDEAD_BEEF, 32'h0,        0);
        req(1, 2'b01, 0, 32'h022, 32'h0000_1234, 32'h0,        0);
        req(0, 2'b01, 0, 32'h022, 32'h0,        32'h0000_1234, 0);
        req(0, 2'b01, 1, 32'h020, 32'h0,        32'h0000_BEEF, 0);
        req(0, 2'b01, 0, 32'h020, 32'h0,        32'hFFFF_BEEF, 0);
        req(0, 2'b10, 0, 32'h020, 32'h0,        32'h1234_BEEF, 0);
        idle(2);

        req(1, 2'b10, 0, 32'h031, 32'hFFFF_FFFF, 32'h0,        1);
        req(1, 2'b01, 0, 32'h031, 32'hFFFF_FFFF, 32'h0,        1);
        req(0, 2'b10, 0, 32'h030, 32'h0,        32'h0000_0000, 0);
        req(0, 2'b01, 0, 32'h033, 32'h0,        32'h0,         1);
        req(0, 2'b10, 0, 32'h022, 32'h0,        32'h0,         1);
        req(0, 2'b11, 0, 32'h010, 32'h0,        32'h0,         1);
`ifdef DMEM_BOUNDS_CHECK_EN
        req(0, 2'b10, 0, 32'h820, 32'h0,        32'h0,         1);
        req(0, 2'b10, 0, 32'h800, 32'h0,        32'h0,         1);
        req(1, 2'b10, 0, 32'h810, 32'hFFFF_FFFF, 32'h0,        1);
        req(0, 2'b10, 0, 32'h010, 32'h0,        32'h0055_7F80, 0);
`else
        req(0, 2'b10, 0, 32'h820, 32'h0,        32'h1234_BEEF, 0);
        req(0, 2'b10, 0, 32'h800, 32'h0,        32'h0000_0000, 0);
`endif
        idle(2);

        for (int i = 0; i < 8; i++) begin
            req(1, 2'b10, 0, 32'h40 + 32'(4 * i), 32'hA500_0000 | 32'(i), 32'h0, 0);
        end
        for (int i = 0; i < 8; i++) begin
            req(0, 2'b10, 0, 32'h40 + 32'(4 * i), 32'h0, 32'hA500_0000 | 32'(i), 0);
        end
        idle(3);

        // reset lands the cycle after a load accept: the latency-2 response must vanish
        req(0, 2'b10, 0, 32'h020, 32'h0, 32'h1234_BEEF, 0);
        rst_n = 1'b0;
        idle(2);
        chk("midreset_ready", {31'd0, rdy1}, 32'd0);
        rst_n = 1'b1;
        wait_init("reinit_cycles");

        req(0, 2'b10, 0, 32'h010, 32'h0, 32'h0, 0);
        req(0, 2'b10, 0, 32'h020, 32'h0, 32'h0, 0);
        req(0, 2'b10, 0, 32'h040, 32'h0, 32'h0, 0);
        req(0, 2'b10, 0, 32'h05C, 32'h0, 32'h0, 0);
        idle(3);

        $display("%0d/%0d checks passed", passed, passed + failed);
        $finish;
    end
endmodule
